// File: rtl/mux8_bus_arbiter.sv
// ============================================================================
// mux8_bus_arbiter : round-robin arbiter/sequencer for the 24-bit 8:1 bus mux.
// Optional source-0 preemption enabled by defining MUX8_ARB_PREEMPT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux8_bus_arbiter #(
   parameter int MAX_HOLD   = 16,
   parameter int GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req,
   input  logic [7:0] done,
   output logic [2:0] sel,
   output logic [7:0] grant,
   output logic       bus_valid,
   output logic       timeout,
   output logic [7:0] owner_cnt
);

   // MAX_HOLD of 256 maps to 0: the 8-bit count wraps there after 255.
   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD % 256);
   localparam logic [1:0] GAP_LAST   = 2'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] grant_q, grant_d;
   logic       bus_valid_q, bus_valid_d;
   logic       timeout_q, timeout_d;
   logic [7:0] owner_cnt_q, owner_cnt_d;
   logic [2:0] ptr_q, ptr_d;
   logic [1:0] gap_cnt_q, gap_cnt_d;

   logic [2:0] win_idx;
   logic       preempt;
   logic       hold_hit;
   logic       normal_rel;

`ifdef MUX8_ARB_PREEMPT_EN
   assign preempt = req[0] && (sel_q != 3'd0) && (owner_cnt_q >= 8'd2);
`else
   assign preempt = 1'b0;
`endif

   assign hold_hit   = (owner_cnt_q == HOLD_LIMIT);
   assign normal_rel = done[sel_q] || !req[sel_q] || preempt;

   // Descending scan so the set bit closest to ptr (circularly) wins.
   always_comb begin
      win_idx = ptr_q;
      for (int k = 7; k >= 0; k--) begin
         if (req[ptr_q + 3'(k)]) begin
            win_idx = ptr_q + 3'(k);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      grant_d     = grant_q;
      bus_valid_d = bus_valid_q;
      timeout_d   = 1'b0;
      owner_cnt_d = owner_cnt_q;
      ptr_d       = ptr_q;
      gap_cnt_d   = gap_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (req != 8'd0) begin
               state_d     = ST_OWN;
               sel_d       = win_idx;
               grant_d     = 8'd1 << win_idx;
               bus_valid_d = 1'b1;
               owner_cnt_d = 8'd1;
            end
         end
         ST_OWN: begin
            if (normal_rel || hold_hit) begin
               state_d     = ST_GAP;
               grant_d     = 8'd0;
               bus_valid_d = 1'b0;
               owner_cnt_d = 8'd0;
               gap_cnt_d   = 2'd0;
               timeout_d   = hold_hit && !normal_rel;
               ptr_d       = preempt ? 3'd0 : sel_q + 3'd1;
            end else begin
               owner_cnt_d = owner_cnt_q + 8'd1;
            end
         end
         ST_GAP: begin
            // sel is deliberately left alone so the mux does not glitch.
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 2'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sel_q       <= 3'd0;
         grant_q     <= 8'd0;
         bus_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         owner_cnt_q <= 8'd0;
         ptr_q       <= 3'd0;
         gap_cnt_q   <= 2'd0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         grant_q     <= grant_d;
         bus_valid_q <= bus_valid_d;
         timeout_q   <= timeout_d;
         owner_cnt_q <= owner_cnt_d;
         ptr_q       <= ptr_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   assign sel       = sel_q;
   assign grant     = grant_q;
   assign bus_valid = bus_valid_q;
   assign timeout   = timeout_q;
   assign owner_cnt = owner_cnt_q;

endmodule

`default_nettype wire

// File: doc/mux8_bus_arbiter.md
Name: mux8_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 24-bit 8-to-1 bus multiplexer in the processor datapath.
- Accepts requests from up to 8 sources and grants the bus to one owner at a time.
- Drives the mux select and a bus-valid qualifier.
- Enforces a bounded ownership time so that no source can starve the others.

Parameters:
- MAX_HOLD, 16, maximum ownership cycles per grant (legal range 2..256).
- GAP_CYCLES, 1, idle cycles between successive grants (legal range 1..4). During these cycles grant=0 and bus_valid=0.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req  input  8  request per source; bit i = source i (mux input A..H)
- done  input  8  release strobe per source; only done[owner] is examined
- sel  output  3  mux select; registered
- grant  output  8  one-hot grant; registered
- bus_valid  output  1  high while an owner holds the bus and sel is stable
- timeout  output  1  one-cycle pulse when an ownership is force-ended by MAX_HOLD
- owner_cnt  output  8  cycles elapsed in the current ownership; 0 when idle

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: sel=0, grant=0, bus_valid=0, timeout=0, owner_cnt=0. Internal priority pointer ptr=0, so source 0 is searched first. State=IDLE.
- Reset asserted mid-ownership: all outputs go to reset values on the next edge. No timeout pulse is generated.
- FSM states: IDLE, OWN, GAP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select winner w = first set bit of req, searching circularly from ptr upward (ptr, ptr+1, ... wrap 7→0).
  - Next edge: sel=w, grant=1<<w, bus_valid=1, owner_cnt=1, state=OWN.
  - Latency from req assertion to grant is exactly 1 cycle.
- OWN:
  - owner_cnt increments by 1 per cycle.
  - Release conditions, evaluated each cycle: (a) done[sel]=1, (b) req[sel]=0, (c) owner_cnt==MAX_HOLD.
  - On release, next edge: grant=0, bus_valid=0, owner_cnt=0, ptr=sel+1 (mod 8), state=GAP.
  - timeout=1 for that single cycle only if (c) holds and neither (a) nor (b) holds.
  - If (a)/(b) coincide with (c), this is a normal release and timeout stays 0.
  - done/req bits of non-owners are ignored while in OWN.
- GAP:
  - Counts GAP_CYCLES cycles with grant=0, then returns to IDLE.
  - sel holds the last owner value throughout; it does not change until the next grant, so there are no glitches on the mux.
  - Requests present during GAP are arbitrated on the first IDLE cycle.
- Ownership is at most MAX_HOLD cycles. Worst-case wait for any continuously requesting source is 7*(MAX_HOLD+GAP_CYCLES+1) cycles.
- grant is always zero or one-hot. bus_valid equals |grant.
- Widths: owner_cnt is 8 bits. MAX_HOLD=256 is reached when owner_cnt wraps to 0 after 255.

Optional Feature:
- Macro: MUX8_ARB_PREEMPT_EN
- Defined:
  - Source 0 is urgent. If req[0]=1 while in OWN with sel!=0 and owner_cnt>=2, the current ownership ends on the next edge as a normal release (timeout=0).
  - ptr is forced to 0 so that source 0 wins the following arbitration.
  - GAP is still honoured.
- Not defined: req[0] has no special treatment and is pure round-robin. All preempt logic is absent.

Test Plan:
- Reset then req=8'b0000_0100, done pulsed on cycle 5 of ownership → grant=8'h04 and sel=2 one cycle after req; bus_valid high for 5 cycles; 1 GAP cycle; ptr=3.
- req=8'hFF held, done never asserted, MAX_HOLD=4 → grants in order 0,1,2,...,7,0. Each lasts 4 cycles with a timeout pulse at the end, followed by 1 gap cycle.
- Owner 3 holding, req[3] dropped at owner_cnt=2 → grant=0 on next edge, timeout=0, ptr=4. If req=8'h09 is pending, the next grant goes to source 3 only after 4..7 and 0 are scanned, so source 0 wins.
- Owner 5 holding, done[5]=1 in the same cycle owner_cnt==MAX_HOLD → release with timeout=0.
- Reset asserted while owner 6 is at owner_cnt=3 → next edge grant=0, sel=0, bus_valid=0, owner_cnt=0. The first grant after reset with req=8'hC0 goes to source 6.
- With MUX8_ARB_PREEMPT_EN defined: owner 4 at owner_cnt=2 and req[0] rises → release next edge, GAP, then grant=8'h01. Without the macro, the same stimulus leaves owner 4 holding until done or timeout.
